// File: rtl/synth_pkg.sv
// Shared types and widths for the voice amplitude path.
package synth_pkg;

  localparam int SAMPLE_W = 8;
  localparam int ENV_W    = 16;

  localparam logic [SAMPLE_W-1:0] SAMPLE_ZERO = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } adsr_stage_t;

endpackage

// File: rtl/envelope_adsr_sample_scaler.sv
// Two-stage offset-binary sample x envelope gain multiply, re-offset to offset binary.
module sample_scaler
  import synth_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic [7:0]          level,
  output logic [SAMPLE_W-1:0] sample_out
);

  logic signed [7:0]  s_q;
  logic        [8:0]  gain_q;
  logic signed [17:0] s_x;
  logic signed [17:0] g_x;
  logic signed [17:0] prod;

  // Full-scale level maps to a gain of exactly 1.0 so the voice can pass through unchanged
  always_comb begin
    s_x  = 18'(s_q);
    g_x  = 18'($signed({1'b0, gain_q}));
    prod = s_x * g_x;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s_q        <= '0;
      gain_q     <= '0;
      sample_out <= SAMPLE_ZERO;
    end else begin
      s_q        <= {~sample_in[7], sample_in[6:0]};
      gain_q     <= (level == 8'hFF) ? 9'd256 : {1'b0, level};
      sample_out <= 8'((prod >>> 8) + 18'sd128);
    end
  end

endmodule

// File: rtl/envelope_adsr.sv
// Per-voice ADSR envelope generator driving the sample scaler.
//   state      | meaning
//   ST_IDLE    | silent, env held at 0
//   ST_ATTACK  | env ramps up to full scale
//   ST_DECAY   | env ramps down to the sustain level
//   ST_SUSTAIN | env tracks the sustain level while gate is held
//   ST_RELEASE | env ramps down to 0 after gate falls
module envelope_adsr
  import synth_pkg::*;
#(
  parameter int PRESCALE   = 16,
  parameter int STEP_SHIFT = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                gate,
  input  logic [7:0]          attack_rate,
  input  logic [7:0]          decay_rate,
  input  logic [7:0]          sustain_level,
  input  logic [7:0]          release_rate,
  input  logic [SAMPLE_W-1:0] waveform_in,
  output logic [SAMPLE_W-1:0] waveform_out,
  output logic [7:0]          level,
  output logic [2:0]          stage,
  output logic                active
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PRESCALE - 1);

  adsr_stage_t       state_q, state_d;
  logic [ENV_W-1:0]  env_q, env_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              gate_d;
  logic              tick, rise, fall;
  logic [ENV_W:0]    att_sum, dec_diff, rel_diff;
  logic [ENV_W-1:0]  sus_env;

  function automatic logic [ENV_W-1:0] step_of(input logic [7:0] rate);
    return {8'b0, rate} << STEP_SHIFT;
  endfunction

  assign tick    = (cnt_q == '0);
  assign rise    = gate & ~gate_d;
  assign fall    = ~gate & gate_d;
  assign sus_env = {sustain_level, 8'h00};

  // 17-bit arithmetic so bit 16 flags overflow (attack) or underflow (decay/release)
  assign att_sum  = {1'b0, env_q} + {1'b0, step_of(attack_rate)};
  assign dec_diff = {1'b0, env_q} - {1'b0, step_of(decay_rate)};
  assign rel_diff = {1'b0, env_q} - {1'b0, step_of(release_rate)};

  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    // Gate transitions win over a coincident tick; env is kept so retrigger is click-free
    if (rise && (state_q == ST_IDLE || state_q == ST_RELEASE)) begin
      state_d = ST_ATTACK;
    end else if (fall && (state_q inside {ST_ATTACK, ST_DECAY, ST_SUSTAIN})) begin
      state_d = ST_RELEASE;
    end else if (tick) begin
      case (state_q)
        ST_IDLE: env_d = '0;
        ST_ATTACK: begin
          if (attack_rate == 8'd0 || att_sum[ENV_W]) begin
            env_d   = '1;
            state_d = ST_DECAY;
          end else begin
            env_d = att_sum[ENV_W-1:0];
          end
        end
        ST_DECAY: begin
          if (decay_rate == 8'd0 || dec_diff[ENV_W] || dec_diff[ENV_W-1:0] <= sus_env) begin
            env_d   = sus_env;
            state_d = ST_SUSTAIN;
          end else begin
            env_d = dec_diff[ENV_W-1:0];
          end
        end
        ST_SUSTAIN: env_d = sus_env;
        ST_RELEASE: begin
          if (release_rate == 8'd0 || rel_diff[ENV_W] || rel_diff[ENV_W-1:0] == '0) begin
            env_d   = '0;
            state_d = ST_IDLE;
          end else begin
            env_d = rel_diff[ENV_W-1:0];
          end
        end
        default: begin
          env_d   = '0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      env_q   <= '0;
      cnt_q   <= '0;
      gate_d  <= 1'b0;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
      gate_d  <= gate;
      cnt_q   <= tick ? CNT_LOAD : cnt_q - 1'b1;
    end
  end

  assign level  = env_q[ENV_W-1:8];
  assign stage  = state_q;
  assign active = (state_q != ST_IDLE);

  sample_scaler u_scaler (
    .clock      (clock),
    .reset      (reset),
    .sample_in  (waveform_in),
    .level      (env_q[ENV_W-1:8]),
    .sample_out (waveform_out)
  );

endmodule
